// File: rtl/arm_cond_pkg.sv
// arm_cond_pkg: condition-code encodings and NZCV bit positions shared by the
//   conditional-execution stage and its condition checker.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Config macro used elsewhere in this slice: PERF_CNT_EN.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_unit_cond_check.sv
// cond_check: evaluates a 4-bit ARM condition field against NZCV flags.
// Latency: combinational, 0 cycles. Backpressure: none (pure function).
// Ports: i_cond [3:0] condition field, i_flags [3:0] {N,Z,C,V}, o_pass 1 = condition holds.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (cond_e'(i_cond))
      EQ: o_pass = w_z;
      NE: o_pass = ~w_z;
      CS: o_pass = w_c;
      CC: o_pass = ~w_c;
      MI: o_pass = w_n;
      PL: o_pass = ~w_n;
      VS: o_pass = w_v;
      VC: o_pass = ~w_v;
      HI: o_pass = w_c & ~w_z;
      LS: o_pass = ~w_c | w_z;
      GE: o_pass = (w_n == w_v);
      LT: o_pass = (w_n != w_v);
      GT: o_pass = ~w_z & (w_n == w_v);
      LE: o_pass = w_z | (w_n != w_v);
      AL: o_pass = 1'b1;
      NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_unit.sv
// cond_logic_unit: conditional-execution stage; holds NZCV, gates decoder writes, updates flags.
// Latency: gated outputs combinational (0 cycles); flags/counters update on the rising clk edge.
// Backpressure: none; every cycle is either an instruction or a bubble (instr_valid=0).
// Ports: clk, reset_n (sync, active-low); instr_valid, cond[3:0], alu_flags[3:0], flag_w[1:0],
//   pcs, reg_w, mem_w, no_write in; cond_ex, pc_src, reg_write, mem_write, flags[3:0] out;
//   exec_cnt/skip_cnt [CNT_W-1:0] out only when PERF_CNT_EN is defined (saturating counters).
module cond_logic_unit
  import arm_cond_pkg::*;
`ifdef PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt,
`endif
  output logic [3:0]       flags
);

  logic [3:0] r_flags;
  logic       w_pass;
  logic       w_cond_ex;

  // Condition is judged against the flags held before this edge
  cond_check u_cond_check (
    .i_cond  (cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign w_cond_ex = instr_valid & w_pass;

  // AND with w_cond_ex keeps unknown decoder requests from escaping when not executing
  assign cond_ex   = w_cond_ex;
  assign pc_src    = pcs & w_cond_ex;
  assign reg_write = reg_w & w_cond_ex & ~no_write;
  assign mem_write = mem_w & w_cond_ex;
  assign flags     = r_flags;

  // Each half of NZCV is written independently; nothing moves unless the instruction executes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else if (w_cond_ex) begin
      if (flag_w[1]) begin
        r_flags[FLAG_N] <= alu_flags[FLAG_N];
        r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        r_flags[FLAG_C] <= alu_flags[FLAG_C];
        r_flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else begin
      if (w_cond_ex && (r_exec_cnt != {CNT_W{1'b1}})) begin
        r_exec_cnt <= r_exec_cnt + CNT_ONE;
      end
      if (instr_valid && !w_pass && (r_skip_cnt != {CNT_W{1'b1}})) begin
        r_skip_cnt <= r_skip_cnt + CNT_ONE;
      end
    end
  end

  assign exec_cnt = r_exec_cnt;
  assign skip_cnt = r_skip_cnt;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
module tb_cond_logic_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs, reg_w, mem_w, no_write;
  logic       cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] flags;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PERF_CNT_EN
  logic [31:0] exec_cnt, skip_cnt;
  logic [3:0]  exec_cnt4, skip_cnt4;
  logic        cond_ex4, pc_src4, reg_write4, mem_write4;
  logic [3:0]  flags4;
`endif

  always #5 clk = ~clk;

  cond_logic_unit u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_w      (flag_w),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .no_write    (no_write),
    .cond_ex     (cond_ex),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
`ifdef PERF_CNT_EN
    .exec_cnt    (exec_cnt),
    .skip_cnt    (skip_cnt),
`endif
    .flags       (flags)
  );

`ifdef PERF_CNT_EN
  cond_logic_unit #(.CNT_W(4)) u_dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_w      (flag_w),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .no_write    (no_write),
    .cond_ex     (cond_ex4),
    .pc_src      (pc_src4),
    .reg_write   (reg_write4),
    .mem_write   (mem_write4),
    .exec_cnt    (exec_cnt4),
    .skip_cnt    (skip_cnt4),
    .flags       (flags4)
  );
`endif

  // Reference condition table, written directly from the architectural definition
  function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic p, input logic rw,
                       input logic mw, input logic nw);
    instr_valid = v; cond = c; flag_w = fw; alu_flags = af;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", flags);
    end
`ifdef PERF_CNT_EN
    tests_run++;
    if (exec_cnt !== 32'd0 || skip_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got exec=%0d skip=%0d expected 0/0", exec_cnt, skip_cnt);
    end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_cmp_beq();
    logic [3:0] af_list [2] = '{4'b0100, 4'b0000};
    logic       exp_pc  [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      // CMP: sets flags, decoder asks for a reg write but no_write suppresses it
      drive(1'b1, 4'b1110, 2'b11, af_list[i], 1'b0, 1'b1, 1'b0, 1'b1);
      tests_run++;
      if (reg_write !== 1'b0 || cond_ex !== 1'b1) begin
        tests_failed++;
        $display("FAIL cmp_regwrite[%0d]: got reg_write=%b cond_ex=%b expected 0/1", i, reg_write, cond_ex);
      end
      step();
      tests_run++;
      if (flags !== af_list[i]) begin
        tests_failed++;
        $display("FAIL cmp_flags[%0d]: got %b expected %b", i, flags, af_list[i]);
      end
      // BEQ
      drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (pc_src !== exp_pc[i]) begin
        tests_failed++;
        $display("FAIL beq_pc_src[%0d]: got %b expected %b", i, pc_src, exp_pc[i]);
      end
      step();
    end
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      tests_run++;
      if (flags !== 4'(f)) begin
        tests_failed++;
        $display("FAIL sweep_load: got %b expected %b", flags, 4'(f));
      end
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 4'(c), 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (cond_ex !== exp_pass(4'(c), 4'(f))) begin
          tests_failed++;
          $display("FAIL sweep cond=%0d flags=%b: got cond_ex=%b expected %b",
                   c, 4'(f), cond_ex, exp_pass(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_split_writes();
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    // Only N,Z written
    drive(1'b1, 4'b1110, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0011) begin
      tests_failed++;
      $display("FAIL split_nz: got %b expected 0011", flags);
    end
    // EQ fails (Z=0): no flag write, no memory write
    drive(1'b1, 4'b0000, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (mem_write !== 1'b0 || cond_ex !== 1'b0) begin
      tests_failed++;
      $display("FAIL failed_memwrite: got mem_write=%b cond_ex=%b expected 0/0", mem_write, cond_ex);
    end
    step();
    tests_run++;
    if (flags !== 4'b0011) begin
      tests_failed++;
      $display("FAIL failed_flags: got %b expected 0011", flags);
    end
    // Only C,V written
    drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'b1110, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b1100) begin
      tests_failed++;
      $display("FAIL split_cv: got %b expected 1100", flags);
    end
    // NV with unknown decoder outputs must leave state and outputs clean
    drive(1'b1, 4'b1111, 2'bxx, 4'bxxxx, 1'bx, 1'bx, 1'bx, 1'bx);
    tests_run++;
    if (pc_src !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL nv_x_outputs: got pc=%b rw=%b mw=%b expected 000", pc_src, reg_write, mem_write);
    end
    step();
    tests_run++;
    if (flags !== 4'b1100) begin
      tests_failed++;
      $display("FAIL nv_x_flags: got %b expected 1100", flags);
    end
  endtask

  task automatic test_bubble_reset();
    drive(1'b0, 4'b1110, 2'b11, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (cond_ex !== 1'b0 || pc_src !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL bubble_outputs: got ce=%b pc=%b rw=%b mw=%b expected 0000",
               cond_ex, pc_src, reg_write, mem_write);
    end
    step();
    tests_run++;
    if (flags !== 4'b1100) begin
      tests_failed++;
      $display("FAIL bubble_flags: got %b expected 1100", flags);
    end
    // Reset wins over an executing flag write
    reset_n = 1'b0;
    drive(1'b1, 4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrun_reset: got %b expected 0000", flags);
    end
    reset_n = 1'b1;
    drive(1'b1, 4'b1110, 2'b11, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0101) begin
      tests_failed++;
      $display("FAIL post_reset_write: got %b expected 0101", flags);
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_n = 1'b0;
    drive(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    tests_run++;
    if (exec_cnt !== 32'd5 || skip_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_counts: got exec=%0d skip=%0d expected 5/3", exec_cnt, skip_cnt);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    tests_run++;
    if (exec_cnt4 !== 4'hF || skip_cnt4 !== 4'h0) begin
      tests_failed++;
      $display("FAIL perf_saturate: got exec4=%h skip4=%h expected f/0", exec_cnt4, skip_cnt4);
    end
    tests_run++;
    if (exec_cnt !== 32'd20) begin
      tests_failed++;
      $display("FAIL perf_wide: got exec=%0d expected 20", exec_cnt);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0; cond = 4'b1110; flag_w = 2'b00; alu_flags = 4'b0000;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    test_reset();
    test_cmp_beq();
    test_cond_sweep();
    test_split_writes();
    test_bubble_reset();
`ifdef PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
